// File: rtl/event_sched_pkg.sv
// Shared types and helpers for the event round-robin task arbiter.
// Holds the FSM state enum and the wrap-around index helper.
package event_sched_pkg;

  localparam int STATE_W    = 2;
  localparam int DROP_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_id.
// Search wraps modulo N_EVENTS; found is low when req is all zero.
module rr_pick
  import event_sched_pkg::*;
#(
  parameter int N_EVENTS = 3,
  parameter int ID_W     = $clog2(N_EVENTS)
) (
  input  logic [N_EVENTS-1:0] req,
  input  logic [ID_W-1:0]     last_id,
  output logic                found,
  output logic [ID_W-1:0]     pick_id
);

  int idx;

  // scan every source once, starting just past the last winner
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    idx     = int'(last_id);
    for (int k = 0; k < N_EVENTS; k++) begin
      idx = next_idx(idx, N_EVENTS);
      if (!found && req[idx]) begin
        found   = 1'b1;
        pick_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/event_rr_task_arbiter.sv
// Latches event rising edges and runs one task at a time, round-robin.
// Optional macro EVENT_DROP_CNT_EN adds a saturating drop_count output.
module event_rr_task_arbiter
  import event_sched_pkg::*;
#(
  parameter int N_EVENTS    = 3,
  parameter int TASK_CYCLES = 4,
  parameter int ID_W        = $clog2(N_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_EVENTS-1:0]   event_in,
  output logic [N_EVENTS-1:0]   task_active,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id,
  output logic [N_EVENTS-1:0]   pending,
  output logic                  drop_pulse
`ifdef EVENT_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count
`endif
);

  localparam int CNT_W =
    (TASK_CYCLES > 1) ? $clog2(TASK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(TASK_CYCLES - 1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [ID_W-1:0]      last_id, last_n;
  logic [ID_W-1:0]      grant_n;
  logic [N_EVENTS-1:0]  event_q;
  logic [N_EVENTS-1:0]  rise;
  logic [N_EVENTS-1:0]  clr;
  logic [N_EVENTS-1:0]  pend_n;
  logic [N_EVENTS-1:0]  active_n;
  logic                 busy_n;
  logic                 drop_n;
  logic                 found;
  logic [ID_W-1:0]      pick_id;

  rr_pick #(
    .N_EVENTS (N_EVENTS),
    .ID_W     (ID_W)
  ) u_pick (
    .req     (pending),
    .last_id (last_id),
    .found   (found),
    .pick_id (pick_id)
  );

  // next-state, grant and pending update; a new rise beats a grant clear
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last_id;
    grant_n  = grant_id;
    active_n = task_active;
    busy_n   = busy;
    clr      = '0;
    rise     = event_in & ~event_q;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n  = pick_id;
          last_n   = pick_id;
          clr      = N_EVENTS'(1) << pick_id;
          active_n = N_EVENTS'(1) << pick_id;
          busy_n   = 1'b1;
          cnt_n    = CNT_LOAD;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          active_n = '0;
          state_n  = GAP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        active_n = '0;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
    endcase
    pend_n = (pending & ~clr) | rise;
    drop_n = |(rise & pending & ~clr);
  end

  // state and output registers; reset aborts any running task
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_id     <= ID_W'(N_EVENTS - 1);
      grant_id    <= '0;
      task_active <= '0;
      busy        <= 1'b0;
      pending     <= '0;
      event_q     <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_id     <= last_n;
      grant_id    <= grant_n;
      task_active <= active_n;
      busy        <= busy_n;
      pending     <= pend_n;
      event_q     <= event_in;
      drop_pulse  <= drop_n;
    end
  end

`ifdef EVENT_DROP_CNT_EN
  // saturating count of lost requests
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_n && drop_count != '1) begin
      drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_event_rr_task_arbiter.sv
// Self-checking bench for event_rr_task_arbiter (N=3, TASK_CYCLES=4).
// Timestamp-based reference model plus directed literal checks.
module tb_event_rr_task_arbiter;

  localparam int N  = 3;
  localparam int TC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ev  = 3'b000;
  logic [2:0] task_active;
  logic       busy;
  logic [1:0] grant_id;
  logic [2:0] pending;
  logic       drop_pulse;
`ifdef EVENT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int asserts = 0;
  int fails   = 0;

  event_rr_task_arbiter #(
    .N_EVENTS    (N),
    .TASK_CYCLES (TC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .event_in    (ev),
    .task_active (task_active),
    .busy        (busy),
    .grant_id    (grant_id),
    .pending     (pending),
    .drop_pulse  (drop_pulse)
`ifdef EVENT_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // reference model: slot is free TC+2 edges after each grant
  int         cyc = 0;
  bit         mvalid = 0;
  logic [2:0] m_pend, m_prev, m_rise, m_clr;
  int         m_last, m_gid, m_start, m_free, m_dcnt, m_pick;
  bit         m_drop;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_pend  = 0;
      m_prev  = 0;
      m_last  = N - 1;
      m_gid   = 0;
      m_start = -100;
      m_free  = 0;
      m_drop  = 0;
      m_dcnt  = 0;
      mvalid  = 1;
    end else begin
      m_rise = ev & ~m_prev;
      m_prev = ev;
      m_clr  = 0;
      if (cyc >= m_free && m_pend != 0) begin
        m_pick = -1;
        for (int j = 1; j <= N; j++)
          if (m_pick < 0 && m_pend[(m_last + j) % N])
            m_pick = (m_last + j) % N;
        m_gid   = m_pick;
        m_last  = m_pick;
        m_clr[m_pick] = 1'b1;
        m_start = cyc;
        m_free  = cyc + TC + 2;
      end
      m_drop = |(m_rise & m_pend & ~m_clr);
      if (m_drop && m_dcnt < 255) m_dcnt++;
      m_pend = (m_pend & ~m_clr) | m_rise;
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_active", int'(task_active),
          (cyc - m_start < TC) ? (1 << m_gid) : 0);
      chk("m_busy", int'(busy),
          (cyc - m_start < TC + 1) ? 1 : 0);
      chk("m_grant", int'(grant_id), m_gid);
      chk("m_pending", int'(pending), int'(m_pend));
      chk("m_drop", int'(drop_pulse), int'(m_drop));
`ifdef EVENT_DROP_CNT_EN
      chk("m_dcnt", int'(drop_count), m_dcnt);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ev  = 3'b000;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    // single event on source 1
    do_reset();
    chk("rst_active", int'(task_active), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_drop", int'(drop_pulse), 0);
    ev = 3'b010; step(1);
    chk("t1_pend", int'(pending), 3'b010);
    chk("t1_act0", int'(task_active), 0);
    step(1);
    chk("t1_act1", int'(task_active), 3'b010);
    chk("t1_gid", int'(grant_id), 1);
    chk("t1_pclr", int'(pending), 0);
    step(1);
    ev = 3'b000; step(2);
    chk("t1_act4", int'(task_active), 3'b010);
    step(1);
    chk("t1_gap_act", int'(task_active), 0);
    chk("t1_gap_busy", int'(busy), 1);
    step(1);
    chk("t1_idle_busy", int'(busy), 0);
    step(2);

    // simultaneous events run 0,1,2
    do_reset();
    ev = 3'b111; step(1);
    ev = 3'b000; step(1);
    chk("t2_first", int'(task_active), 3'b001);
    step(6);
    chk("t2_second", int'(task_active), 3'b010);
    step(6);
    chk("t2_third", int'(task_active), 3'b100);
    step(6);
    chk("t2_done", int'(busy), 0);

    // fairness: source 2 beats re-triggering source 0
    do_reset();
    ev = 3'b001; step(1);
    ev = 3'b000; step(1);
    ev = 3'b100; step(1);
    ev = 3'b001; step(1);
    ev = 3'b000; step(4);
    chk("t3_rr2", int'(task_active), 3'b100);
    step(1);
    ev = 3'b001; step(1);
    ev = 3'b000; step(4);
    chk("t3_rr0", int'(task_active), 3'b001);
    step(8);

    // drop while source 0 waits behind task 1
    do_reset();
    ev = 3'b010; step(1);
    ev = 3'b000; step(1);
    ev = 3'b001; step(1);
    ev = 3'b000; step(1);
    ev = 3'b001; step(1);
    chk("t4_drop", int'(drop_pulse), 1);
`ifdef EVENT_DROP_CNT_EN
    chk("t4_dcnt", int'(drop_count), 1);
`endif
    ev = 3'b000; step(1);
    chk("t4_drop_end", int'(drop_pulse), 0);
    step(2);
    chk("t4_run0", int'(task_active), 3'b001);
    step(6);
    chk("t4_once_busy", int'(busy), 0);
    chk("t4_once_pend", int'(pending), 0);

    // set wins over grant clear
    do_reset();
    ev = 3'b001; step(1);
    ev = 3'b000; step(1);
    ev = 3'b100; step(1);
    ev = 3'b000; step(4);
    ev = 3'b100; step(1);
    chk("t5_run2", int'(task_active), 3'b100);
    chk("t5_keep", int'(pending), 3'b100);
    chk("t5_nodrop", int'(drop_pulse), 0);
    ev = 3'b000; step(6);
    chk("t5_again", int'(task_active), 3'b100);
    chk("t5_pclr", int'(pending), 0);
    step(6);

    // reset in the middle of task 0
    do_reset();
    ev = 3'b001; step(1);
    ev = 3'b110; step(1);
    ev = 3'b000; step(1);
    chk("t6_pend", int'(pending), 3'b110);
    chk("t6_act", int'(task_active), 3'b001);
    rst = 1'b1; step(1);
    chk("t6_act_rst", int'(task_active), 0);
    chk("t6_busy_rst", int'(busy), 0);
    chk("t6_pend_rst", int'(pending), 0);
    chk("t6_gid_rst", int'(grant_id), 0);
    rst = 1'b0;
    ev  = 3'b001; step(1);
    chk("t6_newpend", int'(pending), 3'b001);
    step(1);
    chk("t6_regrant", int'(task_active), 3'b001);
    ev = 3'b000; step(8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
